exc_ctrl: RTL and testbench

//  Exception/interrupt sequencer in front of the CP0 register block. Samples the commit-point (MEM) instruction's

---
 rtl/exc_ctrl_pkg.sv | 43 ++++
 rtl/exc_ctrl_int_sync.sv | 34 +++
 rtl/exc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_exc_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
//   Shared definitions for the exception/interrupt sequencer:
//     - MIPS ExcCode values driven to CP0
//     - bit positions inside the commit-point exception flag vector
//     - FSM state encoding
//     - interrupt-pending helper (Status/Cause masking)
// -----------------------------------------------------------------------------
package exc_pkg;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Bit indices in cm_exc_i = {ades, adel_d, bp, sys, ov, ri, adel_if}
  localparam int BIT_ADEL_IF = 0;
  localparam int BIT_RI      = 1;
  localparam int BIT_OV      = 2;
  localparam int BIT_SYS     = 3;
  localparam int BIT_BP      = 4;
  localparam int BIT_ADEL_D  = 5;
  localparam int BIT_ADES    = 6;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  // An interrupt is pending when globally enabled, not already inside an
  // exception handler, and at least one unmasked IP bit is set.
  function automatic logic int_pending(input logic       ie,
                                       input logic       exl,
                                       input logic [7:0] im,
                                       input logic [7:0] ip);
    return ie & ~exl & (|(im & ip));
  endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// -----------------------------------------------------------------------------
// int_sync
//   Multi-bit level synchronizer: each bit of d passes through STAGES flops.
//   Asynchronous active-low clear of the whole chain. No edge detection.
// Ports
//   clk    in   1      destination clock
//   rst_n  in   1      asynchronous active-low clear
//   d      in   WIDTH  asynchronous inputs
//   q      out  WIDTH  synchronized outputs
// -----------------------------------------------------------------------------
module int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
//   Exception/interrupt sequencer in front of CP0. Samples the commit-point
//   instruction, selects one cause by fixed priority, and issues a one-cycle
//   CP0 exception-entry or ERET strobe together with a fetch redirect
//   (EXC_VECTOR or EPC). Flush is held for FLUSH_CYCLES cycles, stall for the
//   COMMIT cycle only.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   hw_int_i / hw_int_sync_o    raw / synchronized HW5..HW0
//   cm_valid_i, cm_pc_i, cm_in_ds_i, cm_exc_i, cm_if_addr_i, cm_data_addr_i,
//   cm_eret_i                   commit-point instruction information
//   status_i, cause_i, epc_i    CP0 state
//   exc_valid_o, exc_code_o, exc_pc_o, exc_in_ds_o, badvaddr_o, eret_o
//                               CP0 exception-entry / ERET interface
//   flush_o, stall_o, redirect_o, redirect_pc_o
//                               pipeline control and fetch redirect
// -----------------------------------------------------------------------------
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  hw_int_i,
  output logic [5:0]  hw_int_sync_o,
  input  logic        cm_valid_i,
  input  logic [31:0] cm_pc_i,
  input  logic        cm_in_ds_i,
  input  logic [6:0]  cm_exc_i,
  input  logic [31:0] cm_if_addr_i,
  input  logic [31:0] cm_data_addr_i,
  input  logic        cm_eret_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        exc_valid_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_in_ds_o,
  output logic [31:0] badvaddr_o,
  output logic        eret_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  logic             int_pend;
  logic             take_exc_p0;
  logic             take_eret_p0;
  logic [4:0]       code_p0;
  logic [31:0]      bva_p0;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             eret_q;

  logic [4:0]       code_p1;
  logic [31:0]      pc_p1;
  logic             ds_p1;
  logic [31:0]      bva_p1;

  logic             commit;
  logic             unused_ok;

  int_sync #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (hw_int_i),
    .q     (hw_int_sync_o)
  );

  assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  // ---- p0: commit-point cause selection ----
  assign int_pend = int_pending(status_i[0], status_i[1], status_i[15:8], cause_i[15:8]);

  assign take_exc_p0  = cm_valid_i & (int_pend | (|cm_exc_i));
  assign take_eret_p0 = cm_valid_i & cm_eret_i & ~take_exc_p0;

  always_comb begin
    code_p0 = EXC_INT;
    bva_p0  = '0;
    if (int_pend) begin
      code_p0 = EXC_INT;
    end else if (cm_exc_i[BIT_ADEL_IF]) begin
      code_p0 = EXC_ADEL;
      bva_p0  = cm_if_addr_i;
    end else if (cm_exc_i[BIT_RI]) begin
      code_p0 = EXC_RI;
    end else if (cm_exc_i[BIT_OV]) begin
      code_p0 = EXC_OV;
    end else if (cm_exc_i[BIT_SYS]) begin
      code_p0 = EXC_SYS;
    end else if (cm_exc_i[BIT_BP]) begin
      code_p0 = EXC_BP;
    end else if (cm_exc_i[BIT_ADEL_D]) begin
      code_p0 = EXC_ADEL;
      bva_p0  = cm_data_addr_i;
    end else if (cm_exc_i[BIT_ADES]) begin
      code_p0 = EXC_ADES;
      bva_p0  = cm_data_addr_i;
    end
  end

  // ---- p1: sequencer state (commit inputs only sampled in IDLE) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      eret_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_exc_p0) begin
            state_q <= ST_COMMIT;
            eret_q  <= 1'b0;
          end else if (take_eret_p0) begin
            state_q <= ST_COMMIT;
            eret_q  <= 1'b1;
          end
        end
        ST_COMMIT: begin
          if (FLUSH_CYCLES > 1) begin
            state_q <= ST_FLUSH;
            cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          // COMMIT already covered one flush cycle; leave once the last one runs.
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && take_exc_p0) begin
      code_p1 <= code_p0;
      pc_p1   <= cm_pc_i;
      ds_p1   <= cm_in_ds_i;
      bva_p1  <= bva_p0;
    end
  end

  // ---- p1 outputs: decoded from state so reset drops them immediately ----
  assign commit        = (state_q == ST_COMMIT);
  assign exc_valid_o   = commit & ~eret_q;
  assign eret_o        = commit & eret_q;
  assign redirect_o    = commit;
  assign redirect_pc_o = !commit ? 32'h0 : (eret_q ? epc_i : EXC_VECTOR);
  assign flush_o       = commit | (state_q == ST_FLUSH);
  assign stall_o       = commit;
  assign exc_code_o    = exc_valid_o ? code_p1 : 5'h0;
  assign exc_pc_o      = exc_valid_o ? pc_p1   : 32'h0;
  assign exc_in_ds_o   = exc_valid_o & ds_p1;
  assign badvaddr_o    = exc_valid_o ? bva_p1  : 32'h0;

endmodule

// File: tb/tb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_ctrl
//   Directed bench for exc_ctrl. Two instances share the stimulus: dut uses the
//   default FLUSH_CYCLES=2, dut_b uses FLUSH_CYCLES=1. Inputs change and outputs
//   are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_exc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  hw_int_i;
  logic        cm_valid_i;
  logic [31:0] cm_pc_i;
  logic        cm_in_ds_i;
  logic [6:0]  cm_exc_i;
  logic [31:0] cm_if_addr_i;
  logic [31:0] cm_data_addr_i;
  logic        cm_eret_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;

  logic [5:0]  hw_int_sync_o;
  logic        exc_valid_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_pc_o;
  logic        exc_in_ds_o;
  logic [31:0] badvaddr_o;
  logic        eret_o;
  logic        flush_o;
  logic        stall_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  logic [5:0]  hw_int_sync_b;
  logic        exc_valid_b;
  logic [4:0]  exc_code_b;
  logic [31:0] exc_pc_b;
  logic        exc_in_ds_b;
  logic [31:0] badvaddr_b;
  logic        eret_b;
  logic        flush_b;
  logic        stall_b;
  logic        redirect_b;
  logic [31:0] redirect_pc_b;

  int checks   = 0;
  int failures = 0;

  // CP0 model for this bench: Cause.IP[7:2] mirrors the synchronized HW lines.
  assign cause_i = {16'h0, hw_int_sync_o, 10'h0};

  exc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hw_int_i(hw_int_i), .hw_int_sync_o(hw_int_sync_o),
    .cm_valid_i(cm_valid_i), .cm_pc_i(cm_pc_i), .cm_in_ds_i(cm_in_ds_i), .cm_exc_i(cm_exc_i),
    .cm_if_addr_i(cm_if_addr_i), .cm_data_addr_i(cm_data_addr_i), .cm_eret_i(cm_eret_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o), .exc_pc_o(exc_pc_o),
    .exc_in_ds_o(exc_in_ds_o), .badvaddr_o(badvaddr_o), .eret_o(eret_o),
    .flush_o(flush_o), .stall_o(stall_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  exc_ctrl #(.FLUSH_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .hw_int_i(hw_int_i), .hw_int_sync_o(hw_int_sync_b),
    .cm_valid_i(cm_valid_i), .cm_pc_i(cm_pc_i), .cm_in_ds_i(cm_in_ds_i), .cm_exc_i(cm_exc_i),
    .cm_if_addr_i(cm_if_addr_i), .cm_data_addr_i(cm_data_addr_i), .cm_eret_i(cm_eret_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .exc_valid_o(exc_valid_b), .exc_code_o(exc_code_b), .exc_pc_o(exc_pc_b),
    .exc_in_ds_o(exc_in_ds_b), .badvaddr_o(badvaddr_b), .eret_o(eret_b),
    .flush_o(flush_b), .stall_o(stall_b), .redirect_o(redirect_b), .redirect_pc_o(redirect_pc_b)
  );

  logic unused_b;
  assign unused_b = ^{hw_int_sync_b, exc_pc_b, exc_in_ds_b, badvaddr_b, eret_b,
                      stall_b, redirect_b, redirect_pc_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic idle_inputs();
    cm_valid_i     = 1'b0;
    cm_pc_i        = 32'h0;
    cm_in_ds_i     = 1'b0;
    cm_exc_i       = 7'h0;
    cm_if_addr_i   = 32'h0;
    cm_data_addr_i = 32'h0;
    cm_eret_i      = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    hw_int_i = 6'h0;
    status_i = 32'h0;
    epc_i    = 32'h0;
    idle_inputs();

    // Reset state
    cyc(2);
    chk("rst_exc_valid", {31'h0, exc_valid_o}, 32'h0);
    chk("rst_flush",     {31'h0, flush_o},     32'h0);
    chk("rst_stall",     {31'h0, stall_o},     32'h0);
    chk("rst_redir_pc",  redirect_pc_o,        32'h0);
    chk("rst_sync",      {26'h0, hw_int_sync_o}, 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // 1. Overflow at 0x8000_0100
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0100; cm_exc_i = 7'b0000100;
    cyc(1);
    chk("ov_valid",    {31'h0, exc_valid_o}, 32'h1);
    chk("ov_code",     {27'h0, exc_code_o},  32'h0c);
    chk("ov_pc",       exc_pc_o,             32'h8000_0100);
    chk("ov_ds",       {31'h0, exc_in_ds_o}, 32'h0);
    chk("ov_bva",      badvaddr_o,           32'h0);
    chk("ov_eret",     {31'h0, eret_o},      32'h0);
    chk("ov_redir",    {31'h0, redirect_o},  32'h1);
    chk("ov_redir_pc", redirect_pc_o,        32'hBFC0_0380);
    chk("ov_flush0",   {31'h0, flush_o},     32'h1);
    chk("ov_stall0",   {31'h0, stall_o},     32'h1);
    chk("ov_b_valid",  {31'h0, exc_valid_b}, 32'h1);
    idle_inputs();
    cyc(1);
    chk("ov_flush1",   {31'h0, flush_o},     32'h1);
    chk("ov_stall1",   {31'h0, stall_o},     32'h0);
    chk("ov_valid1",   {31'h0, exc_valid_o}, 32'h0);
    chk("ov_b_flush1", {31'h0, flush_b},     32'h0);
    cyc(1);
    chk("ov_flush2",   {31'h0, flush_o},     32'h0);

    // 2. adel_if + ri + ov together
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0004; cm_in_ds_i = 1'b1;
    cm_exc_i = 7'b0000111; cm_if_addr_i = 32'h8000_0003; cm_data_addr_i = 32'h1234_5678;
    cyc(1);
    chk("multi_valid", {31'h0, exc_valid_o}, 32'h1);
    chk("multi_code",  {27'h0, exc_code_o},  32'h04);
    chk("multi_bva",   badvaddr_o,           32'h8000_0003);
    chk("multi_ds",    {31'h0, exc_in_ds_o}, 32'h1);
    idle_inputs();
    cyc(1);
    chk("multi_single", {31'h0, exc_valid_o}, 32'h0);
    cyc(1);

    // adel_d alone: BadVAddr from data address
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0008; cm_exc_i = 7'b0100000;
    cm_data_addr_i = 32'h8000_1001; cm_if_addr_i = 32'h8000_0008;
    cyc(1);
    chk("adeld_code", {27'h0, exc_code_o}, 32'h04);
    chk("adeld_bva",  badvaddr_o,          32'h8000_1001);
    idle_inputs();
    cyc(2);

    // 3. Interrupt on HW0 with IM2 + IE
    status_i = 32'h0000_0401;
    hw_int_i = 6'h01;
    cyc(1);
    chk("sync_stage1", {26'h0, hw_int_sync_o}, 32'h0);
    cyc(1);
    chk("sync_stage2", {26'h0, hw_int_sync_o}, 32'h1);
    chk("int_noval",   {31'h0, exc_valid_o},   32'h0);
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0400;
    cyc(1);
    chk("int_valid", {31'h0, exc_valid_o}, 32'h1);
    chk("int_code",  {27'h0, exc_code_o},  32'h00);
    chk("int_pc",    exc_pc_o,             32'h8000_0400);
    idle_inputs();
    cyc(2);
    status_i = 32'h0000_0403;
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0404;
    cyc(1);
    chk("int_exl_valid", {31'h0, exc_valid_o}, 32'h0);
    chk("int_exl_flush", {31'h0, flush_o},     32'h0);
    idle_inputs();
    hw_int_i = 6'h0;
    status_i = 32'h0;
    cyc(3);

    // 4. ERET
    epc_i = 32'h8000_0200;
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0500; cm_eret_i = 1'b1;
    cyc(1);
    chk("eret_eret",     {31'h0, eret_o},      32'h1);
    chk("eret_redir_pc", redirect_pc_o,        32'h8000_0200);
    chk("eret_redir",    {31'h0, redirect_o},  32'h1);
    chk("eret_novalid",  {31'h0, exc_valid_o}, 32'h0);
    idle_inputs();
    cyc(2);
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0600; cm_eret_i = 1'b1; cm_exc_i = 7'b0001000;
    cyc(1);
    chk("eretsys_valid",    {31'h0, exc_valid_o}, 32'h1);
    chk("eretsys_code",     {27'h0, exc_code_o},  32'h08);
    chk("eretsys_eret",     {31'h0, eret_o},      32'h0);
    chk("eretsys_redir_pc", redirect_pc_o,        32'hBFC0_0380);
    idle_inputs();
    cyc(2);

    // 5. Back-to-back faulting commits
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0700; cm_exc_i = 7'b0010000;
    cyc(1);
    chk("b2b_code1",   {27'h0, exc_code_o}, 32'h09);
    chk("b2b_b_code1", {27'h0, exc_code_b}, 32'h09);
    cm_pc_i = 32'h8000_0704; cm_exc_i = 7'b0000010;
    cyc(1);
    chk("b2b_valid2",   {31'h0, exc_valid_o}, 32'h0);
    chk("b2b_b_valid2", {31'h0, exc_valid_b}, 32'h0);
    chk("b2b_b_flush2", {31'h0, flush_b},     32'h0);
    cyc(1);
    chk("b2b_valid3",   {31'h0, exc_valid_o}, 32'h0);
    chk("b2b_b_valid3", {31'h0, exc_valid_b}, 32'h1);
    chk("b2b_b_code3",  {27'h0, exc_code_b},  32'h0a);
    idle_inputs();
    cyc(3);

    // 6. Asynchronous reset during COMMIT
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0800; cm_exc_i = 7'b0001000;
    cyc(1);
    chk("arst_pre_valid", {31'h0, exc_valid_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",    {31'h0, exc_valid_o}, 32'h0);
    chk("arst_flush",    {31'h0, flush_o},     32'h0);
    chk("arst_stall",    {31'h0, stall_o},     32'h0);
    chk("arst_redir",    {31'h0, redirect_o},  32'h0);
    chk("arst_redir_pc", redirect_pc_o,        32'h0);
    chk("arst_code",     {27'h0, exc_code_o},  32'h0);
    idle_inputs();
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("arst_idle_flush", {31'h0, flush_o}, 32'h0);
    cm_valid_i = 1'b1; cm_pc_i = 32'h8000_0900; cm_exc_i = 7'b0000100;
    cyc(1);
    chk("arst_after_valid", {31'h0, exc_valid_o}, 32'h1);
    chk("arst_after_code",  {27'h0, exc_code_o},  32'h0c);
    idle_inputs();
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
